// File: rtl/ovl_cycle_sequence_monitor_if.sv
// Bundle between the cycle-sequence tracker side and the sequence monitor:
// tracker state and events in, violation/coverage results out.
interface ovl_cycle_sequence_monitor_if #(
    parameter int num_cks = 2,
    parameter int CNT_W   = 8
);
    localparam int EV_W = (num_cks > 1) ? num_cks : 1;
    localparam int FV_W = (num_cks > 2) ? num_cks - 1 : 1;

    logic              clear;
    logic [EV_W-1:0]   event_sequence;
    logic [EV_W-1:0]   seq_queue;
    logic              fire;
    logic [1:0]        fire_code;
    logic [FV_W-1:0]   fail_vec;
    logic              fail_sticky;
    logic              cover_trigger;
    logic              cover_complete;
    logic [CNT_W-1:0]  trigger_count;
    logic [CNT_W-1:0]  complete_count;
    logic [CNT_W-1:0]  fail_count;

    modport master (
        output clear, event_sequence, seq_queue,
        input  fire, fire_code, fail_vec, fail_sticky, cover_trigger,
               cover_complete, trigger_count, complete_count, fail_count
    );

    modport slave (
        input  clear, event_sequence, seq_queue,
        output fire, fire_code, fail_vec, fail_sticky, cover_trigger,
               cover_complete, trigger_count, complete_count, fail_count
    );
endinterface

// File: rtl/ovl_cycle_sequence_monitor.sv
// Evaluates event_sequence against the tracker's seq_queue each cycle and
// registers violation, coverage pulses and saturating coverage counters.
module ovl_cycle_sequence_monitor #(
    parameter int num_cks             = 2,
    parameter int necessary_condition = 0,
    parameter int CNT_W               = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    ovl_cycle_sequence_monitor_if.slave    mon
);
    localparam int MOST_PIPE    = 0;
    localparam int FIRST_PIPE   = 1;
    localparam int FIRST_NOPIPE = 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                  input logic en);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (en && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + CNT_W'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    if (num_cks >= 2) begin : g_active
        logic [num_cks-2:0] miss_s;
        logic [num_cks-2:0] fail_vec_next_s;
        logic               retrig_s;
        logic               done_s;
        logic               trig_acc_s;
        logic               code1_next_s;
        logic               fire_next_s;

        logic               fire_r;
        logic [1:0]         fire_code_r;
        logic [num_cks-2:0] fail_vec_r;
        logic               fail_sticky_r;
        logic               cover_trigger_r;
        logic               cover_complete_r;
        logic [CNT_W-1:0]   trigger_count_r;
        logic [CNT_W-1:0]   complete_count_r;
        logic [CNT_W-1:0]   fail_count_r;

        // Next-state violation and coverage terms for the selected trigger mode.
        always_comb begin
            miss_s          = mon.seq_queue[num_cks-1:1] & ~mon.event_sequence[num_cks-2:0];
            retrig_s        = mon.event_sequence[num_cks-1] & (|mon.seq_queue[num_cks-1:1]);
            done_s          = mon.seq_queue[1] & mon.event_sequence[0];
            fail_vec_next_s = {(num_cks-1){1'b0}};
            code1_next_s    = 1'b0;
            trig_acc_s      = mon.event_sequence[num_cks-1];
            case (necessary_condition)
                FIRST_PIPE: begin
                    fail_vec_next_s = miss_s;
                end
                FIRST_NOPIPE: begin
                    // A new trigger while a sequence is in flight is illegal and not accepted.
                    fail_vec_next_s = miss_s;
                    code1_next_s    = retrig_s;
                    trig_acc_s      = mon.event_sequence[num_cks-1] & ~retrig_s;
                end
                MOST_PIPE: begin
                    fail_vec_next_s[0] = miss_s[0];
                end
                default: begin
                    fail_vec_next_s[0] = miss_s[0];
                end
            endcase
            fire_next_s = (|fail_vec_next_s) | code1_next_s;
        end

        // Output flops; clear only affects counters and the sticky flag.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                fire_r           <= 1'b0;
                fire_code_r      <= 2'b00;
                fail_vec_r       <= {(num_cks-1){1'b0}};
                fail_sticky_r    <= 1'b0;
                cover_trigger_r  <= 1'b0;
                cover_complete_r <= 1'b0;
                trigger_count_r  <= {CNT_W{1'b0}};
                complete_count_r <= {CNT_W{1'b0}};
                fail_count_r     <= {CNT_W{1'b0}};
            end else begin
                fire_r           <= fire_next_s;
                fire_code_r      <= {code1_next_s, |fail_vec_next_s};
                fail_vec_r       <= fail_vec_next_s;
                cover_trigger_r  <= trig_acc_s;
                cover_complete_r <= done_s;
                if (mon.clear) begin
                    fail_sticky_r    <= 1'b0;
                    trigger_count_r  <= {CNT_W{1'b0}};
                    complete_count_r <= {CNT_W{1'b0}};
                    fail_count_r     <= {CNT_W{1'b0}};
                end else begin
                    fail_sticky_r    <= fail_sticky_r | fire_next_s;
                    trigger_count_r  <= sat_inc(trigger_count_r, trig_acc_s);
                    complete_count_r <= sat_inc(complete_count_r, done_s);
                    fail_count_r     <= sat_inc(fail_count_r, fire_next_s);
                end
            end
        end

        assign mon.fire           = fire_r;
        assign mon.fire_code      = fire_code_r;
        assign mon.fail_vec       = fail_vec_r;
        assign mon.fail_sticky    = fail_sticky_r;
        assign mon.cover_trigger  = cover_trigger_r;
        assign mon.cover_complete = cover_complete_r;
        assign mon.trigger_count  = trigger_count_r;
        assign mon.complete_count = complete_count_r;
        assign mon.fail_count     = fail_count_r;
    end else begin : g_illegal
        // Illegal sequence length: every output stays at its reset value.
        assign mon.fire           = 1'b0;
        assign mon.fire_code      = 2'b00;
        assign mon.fail_vec       = 1'b0;
        assign mon.fail_sticky    = 1'b0;
        assign mon.cover_trigger  = 1'b0;
        assign mon.cover_complete = 1'b0;
        assign mon.trigger_count  = {CNT_W{1'b0}};
        assign mon.complete_count = {CNT_W{1'b0}};
        assign mon.fail_count     = {CNT_W{1'b0}};
    end
endmodule

// File: doc/ovl_cycle_sequence_monitor.md
# ovl_cycle_sequence_monitor

Downstream consumer of the cycle-sequence tracker, which produces the `seq_queue` pipeline. It evaluates `event_sequence` against `seq_queue` every cycle and reports violations as a registered fire pulse with a per-position failure vector. It also produces coverage pulses and saturating trigger/complete/fail counters. It is instantiated in place of the empty assert/assume/cover shells when the checker runs in plain-Verilog (non-PSL) mode.

## Interface
- `num_cks`, 2: sequence length; values < 2 are illegal (`ovl_error_t` at init, outputs held at reset values).
- `necessary_condition`, 0: 0 = TRIGGER_ON_MOST_PIPE, 1 = TRIGGER_ON_FIRST_PIPE, 2 = TRIGGER_ON_FIRST_NOPIPE.
- `CNT_W`, 8: width of each coverage counter.
- `clk`  in  1: clock, all state updates on posedge.
- `reset_n`  in  1: reset, **asynchronous, active-low**.
- `clear`  in  1: synchronous clear of counters and `fail_sticky`.
- `event_sequence`  in  num_cks: bit num_cks-1 is the first (trigger) event, bit 0 is the last.
- `seq_queue`  in  num_cks: tracker state; bit i set = events num_cks-1..i seen in consecutive cycles.
- `fire`  out  1: one-cycle violation pulse.
- `fire_code`  out  2: bit0 = missing event, bit1 = illegal retrigger (mode 2 only).
- `fail_vec`  out  num_cks-1: bit i set = expected event i absent.
- `fail_sticky`  out  1: set on any fire, cleared by `clear` or reset.
- `cover_trigger`  out  1: pulse, trigger accepted.
- `cover_complete`  out  1: pulse, full sequence observed.
- `trigger_count`, `complete_count`, `fail_count`  out  CNT_W each: saturating counters.

## Operation
- Combinational terms, sampled at each posedge:
  - `miss[i] = seq_queue[i+1] & ~event_sequence[i]`, for i = 0..num_cks-2.
  - `retrig = event_sequence[num_cks-1] & |seq_queue[num_cks-1:1]`.
  - `done = seq_queue[1] & event_sequence[0]`.
- Mode 0 (MOST_PIPE): `fail_vec_next = {num_cks-2 zeros, miss[0]}`. Only the final event is checked. `retrig` is ignored.
- Mode 1 (FIRST_PIPE): `fail_vec_next = miss` (all positions). `retrig` is ignored; overlapping sequences are legal.
- Mode 2 (FIRST_NOPIPE): `fail_vec_next = miss`, `fire_code[1] = retrig`.
  - `trig_acc = event_sequence[num_cks-1] & ~retrig`. In modes 0/1, `trig_acc = event_sequence[num_cks-1]`.
- Fire terms:
  - `fire_next = |fail_vec_next | fire_code1_next`.
  - `fire_code[0]` = `|fail_vec_next`.
  - `fire_next` sets `fail_sticky`.
- Counters:
  - `trigger_count` +1 on `trig_acc`.
  - `complete_count` +1 on `done`.
  - `fail_count` +1 per cycle with `fire_next`. This is per cycle, not per failing bit.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- `clear` zeroes all three counters and `fail_sticky` at that edge and takes priority over a same-edge increment or set. `clear` does not suppress `fire`, `fail_vec`, `fire_code` or the cover pulses.
- `done` and a miss at a deeper position may coexist in the same cycle (mode 1, overlapping sequences). Both are reported in that cycle.
- Reset (async assert, any time including mid-sequence):
  - All outputs go to 0 immediately.
  - Counters are 0.
  - In-flight sequences are not reported after reset release, because the upstream tracker also clears `seq_queue`.

## Timing
- Every output is a flop. A condition sampled at edge k is visible after edge k and lasts exactly one cycle, unless it is re-sampled at edge k+1.
- Latency from the input condition to `fire`/`cover_*` is 1 cycle. Counter values reflect the edge-k event after edge k.
- No handshake. Inputs are assumed valid every cycle that `reset_n` = 1.
- Reset release is synchronous to `clk` via the upstream reset synchronizer. The first sampling edge is the first posedge with `reset_n` = 1.

## Test plan
Unless noted: `num_cks` = 3, `CNT_W` = 4, and the bench drives `event_sequence`/`seq_queue` directly.
- Mode 0, pass: `seq_queue` = 3'b010, ev = 3'b001 → next cycle `cover_complete` = 1, `complete_count` = 1, `fire` = 0.
- Mode 0, miss: `seq_queue` = 3'b010, ev = 3'b000 → `fire` = 1, `fire_code` = 2'b01, `fail_vec` = 2'b01, `fail_count` = 1, `fail_sticky` = 1. Next idle cycle: `fire` = 0, `fail_sticky` stays 1.
- Mode 1, middle miss: `seq_queue` = 3'b100, ev = 3'b000 → `fail_vec` = 2'b10, `fire` = 1. Repeat with mode 0 → `fire` = 0.
- Mode 2, retrigger: `seq_queue` = 3'b100, ev = 3'b110 → `fire_code` = 2'b10, `cover_trigger` = 0, `trigger_count` unchanged. Same stimulus in mode 1 → `fire` = 0, `cover_trigger` = 1.
- Saturation and clear:
  - 20 consecutive ev = 3'b100 in mode 1 → `trigger_count` = 15, held.
  - Then `clear` = 1 with ev = 3'b100 → `trigger_count` = 0, `cover_trigger` = 1.
- Async reset mid-sequence: `fire` = 1 and counters nonzero; drop `reset_n` between edges → all outputs 0 before the next posedge. Release → counters restart from 0.
